usb_reg_sequencer: RTL
======================

USB_REG_SEQUENCER -- requirements
Module: usb_reg_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: single clock for all logic.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have ports req_valid[1:0], input, 2: per-requester access request; index 0 is the CPU, index 1 is the interrupt service.
REQ-004 SHALL have ports req_write[1:0], input, 2: 1 selects a register write, 0 selects a register read.
REQ-005 SHALL have ports req_reg[1:0], input, 2x8: target chip register index.
REQ-006 SHALL have ports req_wdata[1:0], input, 2x8: write data.
REQ-007 SHALL have ports req_done[1:0], output, 2: one-cycle completion pulse.
REQ-008 SHALL have port req_rdata, output, 8: read result, valid only with req_done.
REQ-009 SHALL have port req_err, output, 1: timeout flag, valid only with req_done.
REQ-010 SHALL have ports dev_read and dev_write, output, 1 each: byte-access strobes to the USB byte controller.
REQ-011 SHALL have port dev_a0, output, 1: 0 selects the index phase, 1 selects the data phase.
REQ-012 SHALL have port dev_wdata, output, 8: byte to the controller.
REQ-013 SHALL have port dev_rdata, input, 8: byte from the controller.
REQ-014 SHALL have port dev_stall, input, 1: controller busy.

Function
REQ-015 SHALL use states IDLE, IDX_REQ, IDX_WAIT, DAT_REQ, DAT_WAIT, DONE.
REQ-016 In IDLE with any req_valid high, SHALL grant one requester round-robin: priority goes to the requester not granted last; after reset, requester 0 has priority.
REQ-017 On grant, SHALL latch write, reg and wdata, then enter IDX_REQ.
REQ-018 In IDX_REQ, SHALL drive dev_write=1, dev_a0=0, dev_wdata=reg, and hold them until dev_stall=1, then go to IDX_WAIT.
REQ-019 In IDX_WAIT, SHALL deassert dev_read and dev_write, and enter DAT_REQ when dev_stall=0.
REQ-020 In DAT_REQ, SHALL drive dev_a0=1 with dev_write=1 and dev_wdata=wdata for a write, or dev_read=1 for a read, until dev_stall=1, then go to DAT_WAIT.
REQ-021 In DAT_WAIT, SHALL keep the strobes low; when dev_stall=0, SHALL capture dev_rdata for a read and enter DONE.
REQ-022 In DONE, SHALL pulse req_done[grant] for exactly one cycle, drive req_rdata and req_err, and return to IDLE.
REQ-023 SHALL never assert dev_read and dev_write in the same cycle.
REQ-024 SHALL keep strobes low in every WAIT state, so the controller sees no repeat request.
REQ-025 A requester SHALL hold req_valid and its fields stable until its req_done; changes before then are ignored after latch.
REQ-026 Simultaneous req_valid SHALL be resolved by REQ-016; the loser stays pending with no loss.
REQ-027 Back-to-back requests from the same requester SHALL alternate with a pending other requester.
REQ-028 Minimum latency SHALL be 6 cycles from grant to req_done, given a stall of one cycle per phase.

Reset
REQ-029 While rst_n=0, SHALL set state=IDLE and drive all outputs to 0 (req_done, req_rdata, req_err, dev_read, dev_write, dev_a0, dev_wdata), with round-robin priority set to requester 0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no req_done.

Configuration
REQ-031 With USB_SEQ_TIMEOUT_EN defined, SHALL run an 8-bit counter in each REQ/WAIT state, cleared on state change; at 255, SHALL enter DONE with req_err=1, req_rdata=0 and strobes low.
REQ-032 Without USB_SEQ_TIMEOUT_EN, SHALL have no counter, SHALL wait indefinitely, and SHALL tie req_err to 0.

Structure
REQ-033 SHALL place the state enum, the A0_INDEX/A0_DATA constants and the timeout limit (255) in the shared peripheral package.
REQ-034 SHALL contain one sub-module, usb_rr_arbiter (2-way round-robin grant), with the FSM in the top module.

Verification
REQ-035 Stimulus: requester 0 writes reg 0x05 data 0xA5 against a controller model with a 4-cycle stall. Response: dev_a0=0/0x05, then dev_a0=1/0xA5, and one req_done[0] with req_err=0.
REQ-036 Stimulus: requester 1 reads reg 0x0D while the model returns 0x3C. Response: req_done[1] with req_rdata=0x3C.
REQ-037 Stimulus: both requesters raise req_valid in the same cycle after reset. Response: requester 0 is served first, then requester 1, and no dev strobe overlaps.
REQ-038 Stimulus: requester 0 issues three back-to-back requests while requester 1 is pending. Response: grant order 0,1,0,0.
REQ-039 Stimulus: rst_n=0 pulsed during DAT_WAIT. Response: all outputs 0, state IDLE, no req_done.
REQ-040 Stimulus: with USB_SEQ_TIMEOUT_EN defined, dev_stall is held at 0 forever. Response: req_done with req_err=1 after 256 cycles in IDX_REQ.

Source files
------------

// File: rtl/usb_reg_sequencer_pkg.sv
// Shared definitions for the USB register sequencer.
//   seq_state_e   : sequencer FSM states
//   A0_INDEX/DATA : dev_a0 phase selects
//   TIMEOUT_LIMIT : per-state cycle limit when USB_SEQ_TIMEOUT_EN is defined
package usb_reg_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IDX_REQ  = 3'd1,
    IDX_WAIT = 3'd2,
    DAT_REQ  = 3'd3,
    DAT_WAIT = 3'd4,
    DONE     = 3'd5
  } seq_state_e;

  localparam logic       A0_INDEX      = 1'b0;
  localparam logic       A0_DATA       = 1'b1;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/usb_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clk, rst_n   : clock, async active-low reset
//   req_i[1:0]   : request lines
//   accept_i     : grant is consumed this cycle (priority rotates)
//   gnt_valid_o  : at least one request present
//   gnt_idx_o    : granted requester
// Priority goes to the requester not granted last; requester 0 after reset.
module usb_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_valid_o = |req_i;
    if (&req_i) gnt_idx_o = prio_q;
    else        gnt_idx_o = req_i[1];
    prio_d = prio_q;
    if (accept_i && gnt_valid_o) prio_d = ~gnt_idx_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/usb_reg_sequencer.sv
// Sequences register accesses from two requesters (0 = CPU, 1 = interrupt
// service) onto a USB byte controller as an index phase (A0=0) followed by a
// data phase (A0=1).
//   clk, rst_n                    : clock, async active-low reset
//   req_valid_i/write_i/reg_i/wdata_i : per-requester access request
//   req_done_o                    : one-cycle completion pulse per requester
//   req_rdata_o, req_err_o        : result, valid with req_done_o
//   dev_read_o/dev_write_o/dev_a0_o/dev_wdata_o : controller strobes and byte
//   dev_rdata_i, dev_stall_i      : controller byte and busy
// Optional: USB_SEQ_TIMEOUT_EN adds a per-state timeout that completes the
// access with req_err_o=1.
//
// state    | meaning
// IDLE     | waiting for a request, arbitration
// IDX_REQ  | index byte strobed until controller stalls
// IDX_WAIT | strobes low, wait for stall release
// DAT_REQ  | data read/write strobed until controller stalls
// DAT_WAIT | strobes low, wait for stall release, capture read byte
// DONE     | completion pulse to the granted requester
module usb_reg_sequencer
  import usb_reg_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid_i,
  input  logic [1:0]      req_write_i,
  input  logic [1:0][7:0] req_reg_i,
  input  logic [1:0][7:0] req_wdata_i,
  output logic [1:0]      req_done_o,
  output logic [7:0]      req_rdata_o,
  output logic            req_err_o,
  output logic            dev_read_o,
  output logic            dev_write_o,
  output logic            dev_a0_o,
  output logic [7:0]      dev_wdata_o,
  input  logic [7:0]      dev_rdata_i,
  input  logic            dev_stall_i
);

  seq_state_e state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       write_q, write_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       gnt_valid, gnt_idx;

`ifdef USB_SEQ_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       tmo;
`endif

  usb_rr_arbiter u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid_i),
    .accept_i    (state_q == IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    write_d     = write_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    req_done_o  = 2'b00;
    req_rdata_o = 8'h00;
    req_err_o   = 1'b0;
    dev_read_o  = 1'b0;
    dev_write_o = 1'b0;
    dev_a0_o    = A0_INDEX;
    dev_wdata_o = 8'h00;
`ifdef USB_SEQ_TIMEOUT_EN
    err_d = err_q;
    tmo   = (state_q inside {IDX_REQ, IDX_WAIT, DAT_REQ, DAT_WAIT}) &&
            (cnt_q == TIMEOUT_LIMIT);
`endif

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gnt_d   = gnt_idx;
          write_d = req_write_i[gnt_idx];
          reg_d   = req_reg_i[gnt_idx];
          wdata_d = req_wdata_i[gnt_idx];
          rdata_d = 8'h00;
`ifdef USB_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = IDX_REQ;
        end
      end
      IDX_REQ: begin
        dev_write_o = 1'b1;
        dev_a0_o    = A0_INDEX;
        dev_wdata_o = reg_q;
        if (dev_stall_i) state_d = IDX_WAIT;
      end
      IDX_WAIT: begin
        if (!dev_stall_i) state_d = DAT_REQ;
      end
      DAT_REQ: begin
        dev_a0_o = A0_DATA;
        if (write_q) begin
          dev_write_o = 1'b1;
          dev_wdata_o = wdata_q;
        end else begin
          dev_read_o  = 1'b1;
        end
        if (dev_stall_i) state_d = DAT_WAIT;
      end
      DAT_WAIT: begin
        if (!dev_stall_i) begin
          if (!write_q) rdata_d = dev_rdata_i;
          state_d = DONE;
        end
      end
      DONE: begin
        req_done_o[gnt_q] = 1'b1;
        req_rdata_o       = rdata_q;
`ifdef USB_SEQ_TIMEOUT_EN
        req_err_o         = err_q;
`endif
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef USB_SEQ_TIMEOUT_EN
    // A timed-out access completes with an error and no further strobes.
    if (tmo) begin
      state_d     = DONE;
      err_d       = 1'b1;
      rdata_d     = 8'h00;
      dev_read_o  = 1'b0;
      dev_write_o = 1'b0;
    end
    cnt_d = (state_d != state_q) ? 8'h00 : cnt_q + 8'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      write_q <= 1'b0;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      write_q <= write_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef USB_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule
